seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Sequential unsigned N-bit restoring divider, one quotient bit per clock.
- Inverse datapath of the multiplier/adder chain: computes quotient and remainder from dividend and divisor.
- Sits beside the low-power 8-bit multiplier. Reuses a ripple-carry subtract: adder with divisor inverted and carry-in 1.
- Single shared subtractor and shift registers, no combinational array, to keep area and toggling low.

Parameters:
- N, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe, sampled only in IDLE.
- dividend  input  N  unsigned dividend, latched on the accepted start.
- divisor  input  N  unsigned divisor, latched on the accepted start.
- busy  output  1  high in CALC and DONE; start is ignored while high.
- done  output  1  one-cycle completion pulse.
- quotient  output  N  result quotient, held until the next completion.
- remainder  output  N  result remainder, held until the next completion.
- div_by_zero  output  1  flag qualifying the held result; high when the last completed operation had divisor==0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State is IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers (R, Q, D, count) are cleared.
  - Reset asserted mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1 and divisor!=0: D<=divisor, Q<=dividend, R (N+1 bits)<=0, count<=0, go to CALC.
  - On an edge with start=1 and divisor==0: go to DONE with quotient<=all ones, remainder<=dividend, div_by_zero<=1.
  - start=0: stay in IDLE.
- CALC, each edge performs one iteration:
  - Shift: R'={R[N-1:0],Q[N-1]}, Q'={Q[N-2:0],0}.
  - Trial: T=R'-{0,D}, computed N+1 bits wide.
  - If T is non-negative (no borrow, T[N]=0): R<=T and Q<=Q' with bit0 set to 1.
  - Otherwise: R<=R' and Q<=Q' (restore).
  - count increments each iteration. On the iteration where count==N-1: load quotient and remainder from the final Q and R[N-1:0], set div_by_zero<=0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE unconditionally.
- Latency:
  - Normal operation: done is high in the cycle following the N-th edge after the start-sampling edge. For N=8 this is 9 cycles from start to done.
  - Divide by zero: done is high in the cycle following the start-sampling edge.
- Throughput: one operation per N+2 cycles (accept, N iterations, DONE).
- Handshake:
  - start is level-sampled in IDLE only.
  - start held high continuously launches a new operation on every IDLE edge.
  - start in CALC or DONE is dropped, not queued.
  - Operand changes after acceptance have no effect.
- Outputs quotient, remainder and div_by_zero change only on completion; they are stable during CALC.
- Boundaries:
  - dividend<divisor gives quotient 0, remainder dividend.
  - divisor=1 gives quotient dividend, remainder 0.
  - dividend=0 gives 0,0 with full latency.
  - The remainder is always less than the divisor; the N+1-bit R prevents overflow when the divisor MSB is set.

Test Plan:
- 200/7 with N=8 -> busy rises next cycle; done 9 cycles after start; quotient=28, remainder=4, div_by_zero=0.
- 255/255 then 5/9, issued back-to-back -> 1,0 then 0,5. A start held high during the first operation's DONE cycle is ignored; it is accepted on the following IDLE edge.
- 255/1 and 0/13 -> 255,0 and 0,0; each takes the full 9-cycle latency.
- 100/0 -> done one cycle after start; quotient=255, remainder=100, div_by_zero=1. A following 9/3 gives 3,0 with div_by_zero=0.
- start pulsed with new operands (50/5) during CALC of 200/7 -> ignored; result remains 28,4. Changing the dividend input mid-CALC has no effect.
- rst_n pulled low asynchronously at iteration 4 of 200/7 -> busy, done and outputs go to 0 immediately, with no done pulse. After release, 17/4 gives 4,1.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned N-bit restoring divider, one quotient bit per clock,
// built around one shared ripple-carry subtractor (adder with inverted divisor, carry-in 1).
module seq_restoring_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e state_q, state_d;
  // The kept partial remainder is always below D, so only N bits are stored;
  // the shifted trial value below is the full N+1-bit R.
  logic [N-1:0] r_q, r_d;
  logic [N:0] r_sh, d_ext, t, c;
  logic [N-1:0] q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d, last;
  assign r_sh  = {r_q, q_q[N-1]};
  assign d_ext = {1'b0, d_q};
  assign last  = cnt_q == CW'(N - 1);
  assign c[0]  = 1'b1;
  for (genvar i = 0; i <= N; i++) begin : g_sub
    assign t[i] = r_sh[i] ^ ~d_ext[i] ^ c[i];
    if (i < N) begin : g_carry
      assign c[i+1] = (r_sh[i] & ~d_ext[i]) | (c[i] & (r_sh[i] ^ ~d_ext[i]));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ((divisor == '0) ? DONE : CALC) : IDLE;
      CALC:    state_d = last ? DONE : CALC;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end
  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (state_q == IDLE && start) begin
      if (divisor == '0) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end else begin
        d_d   = divisor;
        q_d   = dividend;
        r_d   = '0;
        cnt_d = '0;
      end
    end else if (state_q == CALC) begin
      r_d   = t[N] ? r_sh[N-1:0] : t[N-1:0];
      q_d   = {q_q[N-2:0], ~t[N]};
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        quot_d = q_d;
        rem_d  = r_d;
        dbz_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed stimulus with a result scoreboard for the 8-bit divider.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  typedef struct packed {logic [7:0] q; logic [7:0] r; logic z;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  seq_restoring_divider #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e = (b == 0) ? '{q: 8'hff, r: a, z: 1'b1} : '{q: a / b, r: a % b, z: 1'b0};
    return e;
  endfunction
  task automatic go(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    dividend = a;
    divisor = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int lat);
    int n = 1;
    exp_t e;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_quot"}, quotient, e.q);
      chk({tag, "_rem"}, remainder, e.r);
      chk({tag, "_dbz"}, div_by_zero, e.z);
    end
  endtask
  task automatic post(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    exp_t dropped;
    int pulses;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    go(200, 7);
    chk("a_busy_rise", busy, 1);
    wait_done("a_200_7", 9);
    post("a");
    go(255, 255);
    wait_done("b_255_255", 9);
    start = 1'b1;
    dividend = 5;
    divisor = 9;
    @(negedge clk);
    chk("b_done_start_ignored", busy, 0);
    chk("b_done_once", done, 0);
    sb.push_back(model(5, 9));
    @(negedge clk);
    start = 1'b0;
    chk("b_held_accepted", busy, 1);
    wait_done("b_5_9", 9);
    post("b");
    go(255, 1);
    wait_done("c_255_1", 9);
    post("c1");
    go(0, 13);
    wait_done("c_0_13", 9);
    post("c2");
    go(100, 0);
    wait_done("d_100_0", 1);
    post("d1");
    go(9, 3);
    wait_done("d_9_3", 9);
    post("d2");
    go(200, 7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    dividend = 50;
    divisor = 5;
    @(negedge clk);
    start = 1'b0;
    dividend = 99;
    chk("e_quot_stable", quotient, 3);
    chk("e_rem_stable", remainder, 0);
    wait_done("e_200_7", 5);
    post("e");
    go(200, 7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("f_rst_busy", busy, 0);
    chk("f_rst_done", done, 0);
    chk("f_rst_quot", quotient, 0);
    chk("f_rst_rem", remainder, 0);
    chk("f_rst_dbz", div_by_zero, 0);
    dropped = sb.pop_back();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("f_no_done_after_abort", pulses, 0);
    chk("f_dropped_model", dropped.q, 28);
    go(17, 4);
    wait_done("f_17_4", 9);
    post("f");
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
